// File: rtl/sar_ctrl_if.sv
// -----------------------------------------------------------------------------
// sar_ctrl_if
// Readout-side handshake between the digital sequencer and the SAR controller.
//   start         sequencer -> controller   conversion request
//   busy          controller -> sequencer   conversion in progress
//   result[15:0]  controller -> sequencer   final code, zero-extended
//   result_valid  controller -> sequencer   result available
//   result_ready  sequencer -> controller   result accepted
// master = sequencer/readout side, slave = SAR controller.
// -----------------------------------------------------------------------------
interface sar_ctrl_if;
   logic        start;
   logic        busy;
   logic [15:0] result;
   logic        result_valid;
   logic        result_ready;

   modport master (
      output start,
      output result_ready,
      input  busy,
      input  result,
      input  result_valid
   );

   modport slave (
      input  start,
      input  result_ready,
      output busy,
      output result,
      output result_valid
   );
endinterface

// File: rtl/sar_ctrl.sv
// -----------------------------------------------------------------------------
// sar_ctrl
// SAR conversion sequencer for a 16+16 bottom-plate capacitor array.
// A start request runs a sample phase and then an MSB-first binary search
// over the main caps; the diff caps are driven with the complement. The
// comparator is strobed once per bit and the final code is handed out on a
// valid/ready handshake.
// Ports:
//   clk             clock, rising edge
//   rst_n           asynchronous active-low reset
//   bus             readout handshake (start/busy/result/result_valid/result_ready)
//   samp_en         sampling switch enable
//   comp_clk        one-cycle comparator strobe
//   comp_out        comparator decision (1 = keep trial bit)
//   cap_botplate_m  main-cap bottom-plate drive
//   cap_botplate_d  diff-cap bottom-plate drive
// -----------------------------------------------------------------------------
module sar_ctrl #(
   parameter int NBITS         = 16,
   parameter int SAMPLE_CYCLES = 4,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   sar_ctrl_if.slave   bus,
   output logic        samp_en,
   output logic        comp_clk,
   input  logic        comp_out,
   output logic [15:0] cap_botplate_m,
   output logic [15:0] cap_botplate_d
);

   if (NBITS < 1 || NBITS > 16) begin : g_bad_nbits
      $error("sar_ctrl: NBITS must be in 1..16");
   end
   if (SAMPLE_CYCLES < 1 || SETTLE_CYCLES < 1) begin : g_bad_cycles
      $error("sar_ctrl: SAMPLE_CYCLES and SETTLE_CYCLES must be >= 1");
   end

   localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [3:0] TOP_IDX = 4'(NBITS - 1);

   typedef enum logic [2:0] {IDLE, SAMPLE, SETTLE, STROBE, DECIDE, DONE} state_t;

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [3:0]         idx_reg, idx_next;
   logic [15:0]        m_reg, m_next;
   logic [15:0]        d_reg, d_next;
   logic [15:0]        result_reg, result_next;
   logic [15:0]        bit_mask;

   // Bits at or above NBITS are never driven on either cap port.
   for (genvar gi = 0; gi < 16; gi++) begin : g_mask
      if (gi < NBITS) begin : g_used
         assign bit_mask[gi] = 1'b1;
      end else begin : g_unused
         assign bit_mask[gi] = 1'b0;
      end
   end

   // State register and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         idx_reg    <= TOP_IDX;
         m_reg      <= '0;
         d_reg      <= '0;
         result_reg <= '0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         idx_reg    <= idx_next;
         m_reg      <= m_next;
         d_reg      <= d_next;
         result_reg <= result_next;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      idx_next    = idx_reg;
      m_next      = m_reg;
      result_next = result_reg;
      case (state_reg)
         IDLE: begin
            m_next = '0;
            if (bus.start) begin
               state_next = SAMPLE;
               cnt_next   = CNT_W'(SAMPLE_CYCLES);
               idx_next   = TOP_IDX;
            end
         end
         SAMPLE: begin
            if (cnt_reg == CNT_W'(1)) begin
               state_next = SETTLE;
               cnt_next   = CNT_W'(SETTLE_CYCLES);
               m_next     = 16'(1) << TOP_IDX;
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
         SETTLE: begin
            if (cnt_reg == CNT_W'(1)) begin
               state_next = STROBE;
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
         STROBE: begin
            state_next = DECIDE;
         end
         DECIDE: begin
            m_next[idx_reg] = comp_out;
            if (idx_reg != 4'd0) begin
               m_next[idx_reg - 4'd1] = 1'b1;
               idx_next   = idx_reg - 4'd1;
               cnt_next   = CNT_W'(SETTLE_CYCLES);
               state_next = SETTLE;
            end else begin
               // Capture the final code, including this last decision.
               result_next = m_next;
               state_next  = DONE;
            end
         end
         DONE: begin
            // In DONE result_valid is high, so ready alone completes the handshake.
            if (bus.result_ready) begin
               state_next = IDLE;
               m_next     = '0;
               idx_next   = TOP_IDX;
            end
         end
         default: begin
            state_next = IDLE;
            m_next     = '0;
            idx_next   = TOP_IDX;
         end
      endcase
      m_next = m_next & bit_mask;
      result_next = result_next & bit_mask;
      // Diff drive follows the main drive edge-for-edge; held at 0 only in reset.
      d_next = ~m_next & bit_mask;
   end

   // Moore outputs decoded from the state register
   always_comb begin
      bus.busy         = (state_reg != IDLE);
      bus.result_valid = (state_reg == DONE);
      bus.result       = result_reg;
      samp_en          = (state_reg == SAMPLE);
      comp_clk         = (state_reg == STROBE);
      cap_botplate_m   = m_reg;
      cap_botplate_d   = d_reg;
   end

endmodule

// File: tb/tb_sar_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sar_ctrl
// Directed bench for sar_ctrl: a 16-bit instance and an 8-bit instance, each
// with its own comparator model (trial <= target, or tied high/low).
// -----------------------------------------------------------------------------
module tb_sar_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sar_ctrl_if bus16 ();
   sar_ctrl_if bus8 ();

   logic        samp16, cc16, co16;
   logic [15:0] m16, d16;
   logic        samp8, cc8, co8;
   logic [15:0] m8, d8;

   int          mode16 = 0;   // 0: model, 1: tied 1, 2: tied 0
   int          mode8  = 0;
   logic [15:0] target16 = 16'h0000;
   logic [15:0] target8  = 16'h0000;

   assign co16 = (mode16 == 1) ? 1'b1 : (mode16 == 2) ? 1'b0 : (m16 <= target16);
   assign co8  = (mode8  == 1) ? 1'b1 : (mode8  == 2) ? 1'b0 : (m8  <= target8);

   sar_ctrl u_dut16 (
      .clk            (clk),
      .rst_n          (rst_n),
      .bus            (bus16),
      .samp_en        (samp16),
      .comp_clk       (cc16),
      .comp_out       (co16),
      .cap_botplate_m (m16),
      .cap_botplate_d (d16)
   );

   sar_ctrl #(.NBITS(8)) u_dut8 (
      .clk            (clk),
      .rst_n          (rst_n),
      .bus            (bus8),
      .samp_en        (samp8),
      .comp_clk       (cc8),
      .comp_out       (co8),
      .cap_botplate_m (m8),
      .cap_botplate_d (d8)
   );

   int checks = 0;
   int errors = 0;
   int hi_viol = 0;

   // Upper port bits of the 8-bit instance must stay zero at all times.
   always @(negedge clk) begin
      if (((m8 | d8 | bus8.result) & 16'hFF00) != 16'h0000) hi_viol++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   function automatic logic g_valid(input int w);
      return (w == 8) ? bus8.result_valid : bus16.result_valid;
   endfunction
   function automatic logic g_busy(input int w);
      return (w == 8) ? bus8.busy : bus16.busy;
   endfunction
   function automatic logic g_cc(input int w);
      return (w == 8) ? cc8 : cc16;
   endfunction
   function automatic logic g_samp(input int w);
      return (w == 8) ? samp8 : samp16;
   endfunction
   function automatic logic [15:0] g_result(input int w);
      return (w == 8) ? bus8.result : bus16.result;
   endfunction
   function automatic logic [15:0] g_m(input int w);
      return (w == 8) ? m8 : m16;
   endfunction
   function automatic logic [15:0] g_d(input int w);
      return (w == 8) ? d8 : d16;
   endfunction

   task automatic set_start(input int w, input logic v);
      if (w == 8) bus8.start = v; else bus16.start = v;
   endtask
   task automatic set_ready(input int w, input logic v);
      if (w == 8) bus8.result_ready = v; else bus16.result_ready = v;
   endtask

   // Pulse start, then step until result_valid (or stop_at / cycle bound).
   // lat counts edges after the accepting edge E.
   task automatic run_conv(input int w, input int repulse_at, input int stop_at,
                           output int lat, output int pulses, output int samps,
                           output int busy_low);
      @(negedge clk);
      set_start(w, 1'b1);
      @(posedge clk);
      @(negedge clk);
      set_start(w, 1'b0);
      lat = 0; pulses = 0; samps = 0; busy_low = 0;
      while (1) begin
         if (lat == stop_at) break;
         if (g_valid(w)) break;
         if (lat >= 300) break;
         if (g_cc(w)) pulses++;
         if (g_samp(w)) samps++;
         if (!g_busy(w)) busy_low++;
         set_start(w, (lat == repulse_at) ? 1'b1 : 1'b0);
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      set_start(w, 1'b0);
   endtask

   // Hold ready low for hold cycles, then accept; valid must drop one edge later.
   task automatic finish_conv(input int w, input string tag, input logic [15:0] exp_res,
                              input int hold);
      int unstable = 0;
      for (int i = 0; i < hold; i++) begin
         if (!g_valid(w) || g_result(w) !== exp_res) unstable++;
         @(negedge clk);
      end
      check({tag, "_hold_stable"}, 32'(unstable), 32'd0);
      set_ready(w, 1'b1);
      @(posedge clk);
      @(negedge clk);
      set_ready(w, 1'b0);
      check({tag, "_valid_drop"}, {31'd0, g_valid(w)}, 32'd0);
      check({tag, "_m_cleared"}, {16'd0, g_m(w)}, 32'd0);
   endtask

   initial begin
      int lat, pulses, samps, busy_low, idle_busy;
      bus16.start = 1'b0; bus16.result_ready = 1'b0;
      bus8.start  = 1'b0; bus8.result_ready  = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_busy",  {31'd0, bus16.busy}, 32'd0);
      check("rst_samp",  {31'd0, samp16}, 32'd0);
      check("rst_cclk",  {31'd0, cc16}, 32'd0);
      check("rst_valid", {31'd0, bus16.result_valid}, 32'd0);
      check("rst_m",     {16'd0, m16}, 32'd0);
      check("rst_d",     {16'd0, d16}, 32'd0);
      check("rst_res",   {16'd0, bus16.result}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_d16", {16'd0, d16}, 32'h0000FFFF);
      check("idle_d8",  {16'd0, d8},  32'h000000FF);

      // Comparator model, target 0xA5C3
      mode16 = 0; target16 = 16'hA5C3;
      run_conv(16, -1, -1, lat, pulses, samps, busy_low);
      check("a5c3_latency", 32'(lat), 32'd68);
      check("a5c3_pulses",  32'(pulses), 32'd16);
      check("a5c3_samp",    32'(samps), 32'd4);
      check("a5c3_busy",    32'(busy_low), 32'd0);
      check("a5c3_result",  {16'd0, bus16.result}, 32'h0000A5C3);
      check("a5c3_m",       {16'd0, m16}, 32'h0000A5C3);
      check("a5c3_d",       {16'd0, d16}, 32'h00005A3C);
      finish_conv(16, "a5c3", 16'hA5C3, 10);

      // comp_out tied high
      mode16 = 1;
      run_conv(16, -1, -1, lat, pulses, samps, busy_low);
      check("ones_result", {16'd0, bus16.result}, 32'h0000FFFF);
      check("ones_d",      {16'd0, d16}, 32'h00000000);
      finish_conv(16, "ones", 16'hFFFF, 0);

      // comp_out tied low
      mode16 = 2;
      run_conv(16, -1, -1, lat, pulses, samps, busy_low);
      check("zeros_result", {16'd0, bus16.result}, 32'h00000000);
      check("zeros_d",      {16'd0, d16}, 32'h0000FFFF);
      finish_conv(16, "zeros", 16'h0000, 0);

      // start re-pulsed during SETTLE of bit 9 (E+28..E+29)
      mode16 = 0; target16 = 16'h0F0F;
      run_conv(16, 28, -1, lat, pulses, samps, busy_low);
      check("repulse_latency", 32'(lat), 32'd68);
      check("repulse_busy",    32'(busy_low), 32'd0);
      check("repulse_result",  {16'd0, bus16.result}, 32'h00000F0F);
      finish_conv(16, "repulse", 16'h0F0F, 2);
      idle_busy = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus16.busy) idle_busy++;
         @(negedge clk);
      end
      check("repulse_no_second", 32'(idle_busy), 32'd0);

      // Async reset during DECIDE of bit 7 (entered at E+39)
      target16 = 16'hA5C3;
      run_conv(16, -1, 39, lat, pulses, samps, busy_low);
      check("abort_m_before", {16'd0, m16 & 16'hFF00}, 32'h0000A500);
      #1 rst_n = 1'b0;
      #1;
      check("abort_busy",  {31'd0, bus16.busy}, 32'd0);
      check("abort_valid", {31'd0, bus16.result_valid}, 32'd0);
      check("abort_m",     {16'd0, m16}, 32'd0);
      check("abort_d",     {16'd0, d16}, 32'd0);
      check("abort_res",   {16'd0, bus16.result}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      target16 = 16'h3C96;
      run_conv(16, -1, -1, lat, pulses, samps, busy_low);
      check("after_rst_latency", 32'(lat), 32'd68);
      check("after_rst_result",  {16'd0, bus16.result}, 32'h00003C96);
      finish_conv(16, "after_rst", 16'h3C96, 1);

      // NBITS = 8 instance, target 0x5A
      mode8 = 0; target8 = 16'h005A;
      run_conv(8, -1, -1, lat, pulses, samps, busy_low);
      check("n8_latency", 32'(lat), 32'd36);
      check("n8_pulses",  32'(pulses), 32'd8);
      check("n8_result",  {16'd0, bus8.result}, 32'h0000005A);
      check("n8_d",       {16'd0, d8}, 32'h000000A5);
      finish_conv(8, "n8", 16'h005A, 3);
      check("n8_upper_bits", 32'(hi_viol), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
